// File: rtl/timer_cuenta_regresiva.sv
// BCD countdown timer (hh:mm:ss) driven by a 1 Hz tick, with load validation,
// pause control and an alarm held until acknowledged or reloaded.
module timer_cuenta_regresiva (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick_1hz,
    input  logic       cargar,
    input  logic [7:0] hora_in,
    input  logic [7:0] minuto_in,
    input  logic [7:0] segundo_in,
    input  logic       habilitar,
    input  logic       ack,
    output logic [7:0] hora_out,
    output logic [7:0] minuto_out,
    output logic [7:0] segundo_out,
    output logic       corriendo,
    output logic       alarma,
    output logic       error_carga
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSA, FIN} estado_t;

    estado_t    estado_q;
    logic [7:0] hora_q, minuto_q, segundo_q;
    logic       corriendo_q, alarma_q, error_q;

    logic [7:0] hora_d, minuto_d, segundo_d;
    logic       seg_borrow, min_borrow, dec_cero;
    logic       carga_valida, carga_cero;

    // One-second BCD decrement; a zero field wraps to 'tope' (hours use 0, i.e. no wrap).
    function automatic logic [7:0] dec_bcd(input logic [7:0] v, input logic [7:0] tope);
        if (v == 8'h00)
            return tope;
        else if (v[3:0] == 4'd0)
            return {v[7:4] - 4'd1, 4'd9};
        else
            return {v[7:4], v[3:0] - 4'd1};
    endfunction

    always_comb begin
        seg_borrow = (segundo_q == 8'h00);
        min_borrow = seg_borrow && (minuto_q == 8'h00);
        segundo_d  = dec_bcd(segundo_q, 8'h59);
        minuto_d   = seg_borrow ? dec_bcd(minuto_q, 8'h59) : minuto_q;
        hora_d     = min_borrow ? dec_bcd(hora_q, 8'h00) : hora_q;
        dec_cero   = (hora_d == 8'h00) && (minuto_d == 8'h00) && (segundo_d == 8'h00);

        carga_valida = (hora_in[3:0] <= 4'd9) && (minuto_in[3:0] <= 4'd9) &&
                       (segundo_in[3:0] <= 4'd9) && (hora_in <= 8'h23) &&
                       (minuto_in <= 8'h59) && (segundo_in <= 8'h59);
        carga_cero   = (hora_in == 8'h00) && (minuto_in == 8'h00) && (segundo_in == 8'h00);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            estado_q    <= IDLE;
            hora_q      <= 8'h00;
            minuto_q    <= 8'h00;
            segundo_q   <= 8'h00;
            corriendo_q <= 1'b0;
            alarma_q    <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            error_q <= 1'b0;
            if (cargar) begin
                // A rejected load freezes everything, including a coincident tick.
                if (carga_valida) begin
                    hora_q    <= hora_in;
                    minuto_q  <= minuto_in;
                    segundo_q <= segundo_in;
                    if (carga_cero) begin
                        estado_q    <= FIN;
                        corriendo_q <= 1'b0;
                        alarma_q    <= 1'b1;
                    end else if (habilitar) begin
                        estado_q    <= RUN;
                        corriendo_q <= 1'b1;
                        alarma_q    <= 1'b0;
                    end else begin
                        estado_q    <= PAUSA;
                        corriendo_q <= 1'b0;
                        alarma_q    <= 1'b0;
                    end
                end else begin
                    error_q <= 1'b1;
                end
            end else begin
                case (estado_q)
                    IDLE: ;
                    RUN: begin
                        if (!habilitar) begin
                            estado_q    <= PAUSA;
                            corriendo_q <= 1'b0;
                        end else if (tick_1hz) begin
                            hora_q    <= hora_d;
                            minuto_q  <= minuto_d;
                            segundo_q <= segundo_d;
                            if (dec_cero) begin
                                estado_q    <= FIN;
                                corriendo_q <= 1'b0;
                                alarma_q    <= 1'b1;
                            end
                        end
                    end
                    PAUSA: begin
                        if (habilitar) begin
                            estado_q    <= RUN;
                            corriendo_q <= 1'b1;
                        end
                    end
                    FIN: begin
                        if (ack) begin
                            estado_q <= IDLE;
                            alarma_q <= 1'b0;
                        end
                    end
                    default: begin
                        estado_q    <= IDLE;
                        corriendo_q <= 1'b0;
                        alarma_q    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign hora_out    = hora_q;
    assign minuto_out  = minuto_q;
    assign segundo_out = segundo_q;
    assign corriendo   = corriendo_q;
    assign alarma      = alarma_q;
    assign error_carga = error_q;

endmodule

// File: doc/timer_cuenta_regresiva.md
TIMER_CUENTA_REGRESIVA -- requirements
Module: timer_cuenta_regresiva

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 The block SHALL have one clock; reset is synchronous and active-low.
REQ-003 clk  input  1  rising-edge system clock.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 tick_1hz  input  1  one-clk-wide pulse per second; count source.
REQ-006 cargar  input  1  load request, sampled each clk.
REQ-007 hora_in  input  8  BCD hours to load, 00-23.
REQ-008 minuto_in  input  8  BCD minutes to load, 00-59.
REQ-009 segundo_in  input  8  BCD seconds to load, 00-59.
REQ-010 habilitar  input  1  level; 1 = count, 0 = pause.
REQ-011 ack  input  1  clears alarma.
REQ-012 hora_out, minuto_out, segundo_out  output  8 each  registered BCD remaining time.
REQ-013 corriendo  output  1  high in state RUN.
REQ-014 alarma  output  1  high in state FIN.
REQ-015 error_carga  output  1  one-clk pulse on a rejected load.

Function
REQ-016 FSM states SHALL be IDLE, RUN, PAUSA and FIN, encoded in one registered state variable.
REQ-017 Load validity: every BCD nibble <= 9, hours <= 0x23, minutes <= 0x59, seconds <= 0x59.
REQ-018 A valid cargar, in any state, SHALL register the inputs into the outputs on the same edge; next state RUN if habilitar=1, otherwise PAUSA.
REQ-019 A valid load of 00:00:00 SHALL go directly to FIN with alarma=1 on the next edge.
REQ-020 An invalid cargar SHALL leave the time and state unchanged and pulse error_carga for exactly one clk.
REQ-021 In RUN, each tick_1hz with cargar=0 SHALL decrement the time by one second in BCD; the result is visible on the following edge (1-clk latency).
REQ-022 Seconds rule: units 0 borrow from tens; 00 wraps to 59 and borrows from minutes.
REQ-023 Minutes rule: same as seconds; 00 wraps to 59 and borrows from hours.
REQ-024 Hours SHALL decrement in BCD (e.g. 0x10 -> 0x09) and never wrap.
REQ-025 A tick producing 00:00:00 SHALL enter FIN on that edge, with corriendo=0 and alarma=1 simultaneously.
REQ-026 RUN with habilitar=0 -> PAUSA; PAUSA with habilitar=1 -> RUN; ticks are ignored in PAUSA, IDLE and FIN.
REQ-027 In FIN, the time SHALL hold at 00:00:00; alarma holds until ack=1 (-> IDLE) or a valid cargar.
REQ-028 Simultaneous events: cargar beats tick_1hz, ack and habilitar; ack outside FIN has no effect.
REQ-029 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-030 When reset_n=0 at a clk edge: state IDLE, all time outputs 0x00, corriendo=0, alarma=0, error_carga=0.
REQ-031 Reset SHALL take priority over all inputs, including mid-count and in FIN.

Verification
REQ-032 Load 00:01:00 with habilitar=1, one tick -> 00:00:59 one clk after the tick; corriendo=1.
REQ-033 Load 10:00:00, one tick -> 09:59:59 (triple borrow, BCD hour 0x10 -> 0x09).
REQ-034 Load 00:00:02, two ticks -> 00:00:01, then 00:00:00 with alarma=1 and corriendo=0 on the same edge; further ticks leave the time unchanged; ack -> IDLE, alarma=0.
REQ-035 Load 0x24:00:00 or 00:0x5A:00 -> error_carga pulses for 1 clk; prior time and state unchanged.
REQ-036 In RUN at 00:05:00: habilitar=0, 3 ticks -> still 00:05:00 in PAUSA; cargar coincident with a tick -> loaded value, no decrement.
REQ-037 reset_n=0 mid-count at 12:34:56 -> next edge shows 00:00:00, IDLE, all flags 0.
